mux_4x1_rr: RTL and testbench
=============================

// Module: mux_4x1_rr
// PURPOSE
//  4-input to 1-output streaming multiplexer with round-robin arbitration; the collecting counterpart of
//  the 1-to-4 demux fabric. Four producer channels with valid/ready handshakes merge into one registered
//  output stream with valid/ready. Fairness: no requesting channel waits more than 3 grants.
// PARAMETERS
//  WIDTH   8   data width of every input channel and of the output
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   4        per-channel valid, bit k = channel k
//  in_data    in   4*WIDTH  channel k occupies [k*WIDTH +: WIDTH]
//  in_ready   out  4        per-channel ready, bit k = channel k; combinational
//  out_valid  out  1        output register holds a beat
//  out_data   out  WIDTH    registered output data
//  out_ready  in   1        downstream accepts the beat
//  out_id     out  2        channel index of current beat (only with MUX_ID_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, rr_ptr=0.
//  - Output stage: one register slot. load = !out_valid | out_ready.
//  - Arbitration, combinational:
//    - Search in_valid starting at rr_ptr, then rr_ptr+1, rr_ptr+2, rr_ptr+3, wrapping mod 4.
//    - The first set bit is the winner g. With no set bit there is no grant.
//  - in_ready[k] = load & grant & (k==g). At most one in_ready bit is high per cycle.
//  - in_ready depends on in_valid. Producers must not make in_valid depend on in_ready.
//  - Transfer on channel g when in_valid[g] & in_ready[g]. On the next edge:
//    - out_data <= channel g data; out_valid <= 1; out_id <= g.
//    - rr_ptr <= (g+1) mod 4, with wrap 3->0.
//  - load=1 with no request: out_valid <= 0; out_data and out_id hold; rr_ptr holds.
//  - load=0 (out_valid=1, out_ready=0): all in_ready=0; out_* hold stable; rr_ptr holds.
//  - Latency: input transfer at edge N, beat visible on out_* after edge N. Beat leaves when out_valid & out_ready.
//  - Throughput: 1 beat/cycle while out_ready=1; full-rate back-to-back is supported.
//  - Output accept and new input transfer in the same cycle: the register is overwritten with no bubble.
//  - A producer holding valid without a grant keeps in_data stable. The block never drops or duplicates a beat.
//  - rr_ptr advances only on a transfer, never on request alone.
//  - rst asserted mid-transfer: any pending output beat is discarded, and out_valid drops immediately.
//    After release, arbitration restarts from channel 0.
//  - No X propagation: when the output register is not loaded, unselected in_data is never sampled.
// CONFIGURATION
//  MUX_ID_EN defined:
//    - out_id port and register exist.
//    - out_id is reset to 0, loaded with g on every transfer, and held otherwise.
//  MUX_ID_EN undefined:
//    - out_id port and register are absent.
//    - All other behaviour is identical.
// TESTING
//  1 Reset: rst=1 with random inputs -> out_valid=0, out_data=0, in_ready=0000, out_id=0.
//  2 Single channel:
//    - stimulus: in_valid=0100, ch2 data=0xA5, out_ready=1.
//    - response: in_ready=0100 in the same cycle; next cycle out_valid=1, out_data=0xA5, out_id=2.
//  3 Round robin:
//    - stimulus: in_valid=1111 held, out_ready=1, ch k data=0x10+k.
//    - response: output sequence 0x10,0x11,0x12,0x13,0x10; one beat per cycle.
//  4 Backpressure:
//    - stimulus: out_ready=0 with in_valid=0011 after the first beat.
//    - response: out_data frozen; in_ready=0000. out_ready=1 -> next beat comes from ch1, none lost.
//  5 Wrap and skip:
//    - stimulus: last grant ch3, then in_valid=0101.
//    - response: ch0 granted next, then ch2; rr_ptr goes 0->1->3.
//  6 Reset mid-stream:
//    - stimulus: rst pulsed while out_valid=1.
//    - response: out_valid=0 immediately; after release with in_valid=1111, first beat is ch0.

Source files
------------

// File: rtl/mux_4x1_rr.sv
// mux_4x1_rr: four valid/ready producers merged round-robin into one registered output stream.
// Optional out_id port and register are enabled by defining MUX_ID_EN.
module mux_4x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready
`ifdef MUX_ID_EN
  ,
  output logic [1:0]         out_id
`endif
);

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [1:0]       rr_ptr_r;
  logic             load_s;
  logic             grant_s;
  logic [1:0]       gnt_idx_s;
  logic [3:0]       in_ready_s;
  logic [WIDTH-1:0] sel_data_s;
`ifdef MUX_ID_EN
  logic [1:0]       out_id_r;
`endif

  // First requesting channel found scanning upward from ptr, wrapping mod 4; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration and per-channel ready; ready is held low while reset is asserted.
  always_comb begin
    load_s     = (!out_valid_r || out_ready) && !rst;
    {grant_s, gnt_idx_s} = rr_pick(in_valid, rr_ptr_r);
    in_ready_s = 4'b0000;
    if (load_s && grant_s) begin
      in_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      in_ready_s = 4'b0000;
    end
  end

  // Data select for the granted channel only.
  always_comb begin
    sel_data_s = '0;
    case (gnt_idx_s)
      2'd0:    sel_data_s = in_data[0*WIDTH +: WIDTH];
      2'd1:    sel_data_s = in_data[1*WIDTH +: WIDTH];
      2'd2:    sel_data_s = in_data[2*WIDTH +: WIDTH];
      2'd3:    sel_data_s = in_data[3*WIDTH +: WIDTH];
      default: sel_data_s = '0;
    endcase
  end

  // Output slot and round-robin pointer; the pointer moves only on an actual transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      rr_ptr_r    <= 2'd0;
`ifdef MUX_ID_EN
      out_id_r    <= 2'd0;
`endif
    end else if (load_s) begin
      if (grant_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        rr_ptr_r    <= gnt_idx_s + 2'd1;
`ifdef MUX_ID_EN
        out_id_r    <= gnt_idx_s;
`endif
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
`ifdef MUX_ID_EN
  assign out_id    = out_id_r;
`endif

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Directed self-checking bench for mux_4x1_rr: reset, single channel, round robin,
// backpressure, wrap/skip and reset mid-stream; out_id checked when MUX_ID_EN is defined.
module tb_mux_4x1_rr;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready;
`ifdef MUX_ID_EN
  logic [1:0]         out_id;
`endif

  int checks;
  int failures;

  mux_4x1_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef MUX_ID_EN
    ,
    .out_id    (out_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 4'($urandom_range(1, 15));
    in_data   = 32'($urandom);
    out_ready = 1'($urandom);
    @(posedge clk);
    #1;
    in_valid = 4'b1111;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
      failures++;
    end
    checks++;
    if (out_data !== 8'h00) begin
      $display("FAIL reset_out_data got=%h want=00", out_data);
      failures++;
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      $display("FAIL reset_in_ready got=%b want=0000", in_ready);
      failures++;
    end
`ifdef MUX_ID_EN
    checks++;
    if (out_id !== 2'd0) begin
      $display("FAIL reset_out_id got=%0d want=0", out_id);
      failures++;
    end
`endif
    in_valid = 4'b0000;
    rst      = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    in_data   = {8'h33, 8'hA5, 8'h11, 8'h00};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      $display("FAIL single_in_ready got=%b want=0100", in_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      $display("FAIL single_beat got=%b/%h want=1/a5", out_valid, out_data);
      failures++;
    end
`ifdef MUX_ID_EN
    checks++;
    if (out_id !== 2'd2) begin
      $display("FAIL single_out_id got=%0d want=2", out_id);
      failures++;
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_drain got=%b want=0", out_valid);
      failures++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [5];
    logic [3:0] exp_rdy  [5];
    exp_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++;
      if (in_ready !== exp_rdy[j]) begin
        $display("FAIL rr_in_ready[%0d] got=%b want=%b", j, in_ready, exp_rdy[j]);
        failures++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data[j]) begin
        $display("FAIL rr_beat[%0d] got=%b/%h want=1/%h", j, out_valid, out_data, exp_data[j]);
        failures++;
      end
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data   = {8'h23, 8'h22, 8'h21, 8'h20};
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h20) begin
        $display("FAIL bp_hold[%0d] got=%b/%b/%h want=0000/1/20", j, in_ready, out_valid, out_data);
        failures++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      $display("FAIL bp_release_ready got=%b want=0010", in_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h21) begin
      $display("FAIL bp_next_beat got=%b/%h want=1/21", out_valid, out_data);
      failures++;
    end
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      $display("FAIL bp_after_ready got=%b want=0001", in_ready);
      failures++;
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    in_data   = {8'h33, 8'h32, 8'h31, 8'h30};
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_data !== 8'h33) begin
      $display("FAIL wrap_ch3 got=%h want=33", out_data);
      failures++;
    end
    in_valid = 4'b0101;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      $display("FAIL wrap_ready0 got=%b want=0001", in_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_data !== 8'h30 || in_ready !== 4'b0100) begin
      $display("FAIL wrap_ch0 got=%h/%b want=30/0100", out_data, in_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_data !== 8'h32 || in_ready !== 4'b0001) begin
      $display("FAIL skip_ch2 got=%h/%b want=32/0001", out_data, in_ready);
      failures++;
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_data   = {8'h43, 8'h42, 8'h41, 8'h40};
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h40) begin
      $display("FAIL mid_setup got=%b/%h want=1/40", out_valid, out_data);
      failures++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      $display("FAIL mid_async_clear got=%b/%h want=0/00", out_valid, out_data);
      failures++;
    end
    @(posedge clk);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      $display("FAIL mid_restart_ready got=%b want=0001", in_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h40) begin
      $display("FAIL mid_first_beat got=%b/%h want=1/40", out_valid, out_data);
      failures++;
    end
`ifdef MUX_ID_EN
    checks++;
    if (out_id !== 2'd0) begin
      $display("FAIL mid_out_id got=%0d want=0", out_id);
      failures++;
    end
`endif
    in_valid = 4'b0000;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
